// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a one-word holding buffer so that
// back-to-back words stream with no gap bit. Valid/ready load, shift_en consume.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] hb, hb_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hb_full, hb_full_nx;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shift;

  assign accept   = load_valid && load_ready;
  assign last_bit = (cnt == LAST);
  assign sr_shift = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      hb      <= '0;
      cnt     <= '0;
      hb_full <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      hb      <= hb_nx;
      cnt     <= cnt_nx;
      hb_full <= hb_full_nx;
    end
  end

  // Next-state: load, shift, stall and frame-completion handoff
  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    hb_nx      = hb;
    cnt_nx     = cnt;
    hb_full_nx = hb_full;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sr_nx    = parallel_in;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en && last_bit) begin
          // Buffered word wins; load_ready is low then, so no accept can collide
          cnt_nx = '0;
          if (hb_full) begin
            sr_nx      = hb;
            hb_full_nx = 1'b0;
          end else if (accept) begin
            sr_nx = parallel_in;
          end else begin
            sr_nx    = '0;
            state_nx = IDLE;
          end
        end else begin
          if (shift_en) begin
            sr_nx  = sr_shift;
            cnt_nx = cnt + CNT_W'(1);
          end
          if (accept) begin
            hb_nx      = parallel_in;
            hb_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only
  assign serial_valid = (state == SHIFT);
  assign serial_out   = serial_valid && (LSB_FIRST ? sr[0] : sr[WIDTH-1]);
  assign frame_start  = serial_valid && (cnt == '0);
  assign frame_end    = serial_valid && last_bit;
  assign busy         = (state == SHIFT) || hb_full;
  assign load_ready   = !hb_full;

endmodule
